// File: rtl/priority_encoder_4x2.sv
// Registered 4-to-2 priority encoder: x[3] wins, e gates the encode, one clock of latency.
// Define PRIORITY_ENCODER_4X2_VALID_EN to add the registered valid flag v.
module priority_encoder_4x2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] x,
  input  logic       e,
  output logic [1:0] y
`ifdef PRIORITY_ENCODER_4X2_VALID_EN
  ,
  output logic       v
`endif
);

  logic [1:0] enc_idx;
  logic       enc_hit;

  // Disabled or empty request both encode to 00; only v can tell x=0001 apart from them.
  always_comb begin
    enc_idx = 2'b00;
    enc_hit = 1'b0;
    if (e) begin
      enc_hit = |x;
      if (x[3])      enc_idx = 2'b11;
      else if (x[2]) enc_idx = 2'b10;
      else if (x[1]) enc_idx = 2'b01;
      else           enc_idx = 2'b00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= 2'b00;
    end else begin
      y <= enc_idx;
    end
  end

`ifdef PRIORITY_ENCODER_4X2_VALID_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= 1'b0;
    end else begin
      v <= enc_hit;
    end
  end
`else
  logic unused_hit;
  assign unused_hit = enc_hit;
`endif

endmodule

// File: tb/tb_priority_encoder_4x2.sv
// Directed bench for priority_encoder_4x2; checks v as well when PRIORITY_ENCODER_4X2_VALID_EN is defined.
module tb_priority_encoder_4x2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] x   = 4'b0000;
  logic       e   = 1'b0;
  logic [1:0] y;
`ifdef PRIORITY_ENCODER_4X2_VALID_EN
  logic       v;
`endif

  int n_total = 0;
  int n_bad   = 0;

  priority_encoder_4x2 dut (
    .clk(clk),
    .rst(rst),
    .x  (x),
    .e  (e),
    .y  (y)
`ifdef PRIORITY_ENCODER_4X2_VALID_EN
    ,
    .v  (v)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] x;
    logic       e;
    logic [1:0] y;
    logic       v;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [1:0] exp_y, input logic exp_v);
    n_total++;
    if (y !== exp_y) begin
      n_bad++;
      $display("FAIL %s: y=%b expected %b", name, y, exp_y);
    end
`ifdef PRIORITY_ENCODER_4X2_VALID_EN
    n_total++;
    if (v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: v=%b expected %b", name, v, exp_v);
    end
`else
    if (exp_v === 1'bz) $display("note: unreachable");
`endif
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic [3:0] nx, input logic ne);
    @(negedge clk);
    x = nx;
    e = ne;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Priority sweep with e=1, then enable-gated and extra cases.
    vecs[0]  = '{4'b0000, 1'b1, 2'b00, 1'b0};
    vecs[1]  = '{4'b0001, 1'b1, 2'b00, 1'b1};
    vecs[2]  = '{4'b0010, 1'b1, 2'b01, 1'b1};
    vecs[3]  = '{4'b0011, 1'b1, 2'b01, 1'b1};
    vecs[4]  = '{4'b0100, 1'b1, 2'b10, 1'b1};
    vecs[5]  = '{4'b0101, 1'b1, 2'b10, 1'b1};
    vecs[6]  = '{4'b0110, 1'b1, 2'b10, 1'b1};
    vecs[7]  = '{4'b1000, 1'b1, 2'b11, 1'b1};
    vecs[8]  = '{4'b1001, 1'b1, 2'b11, 1'b1};
    vecs[9]  = '{4'b1100, 1'b1, 2'b11, 1'b1};
    vecs[10] = '{4'b1111, 1'b1, 2'b11, 1'b1};
    vecs[11] = '{4'b1111, 1'b0, 2'b00, 1'b0};
    vecs[12] = '{4'b0110, 1'b0, 2'b00, 1'b0};
    vecs[13] = '{4'b0111, 1'b1, 2'b10, 1'b1};
    vecs[14] = '{4'b1010, 1'b1, 2'b11, 1'b1};
    vecs[15] = '{4'b0001, 1'b0, 2'b00, 1'b0};

    // Reset asserted asynchronously with a full request pending.
    x = 4'b1111;
    e = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("reset_async_initial", 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("reset_hold", 2'b00, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_release_first_edge", 2'b11, 1'b1);

    // Enable gating.
    step(4'b1000, 1'b0);
    chk("enable_off", 2'b00, 1'b0);
    step(4'b1000, 1'b1);
    chk("enable_on", 2'b11, 1'b1);

    // Table sweep: one vector per cycle, y follows every cycle.
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].x, vecs[i].e);
      chk($sformatf("vec%0d_x%b_e%b", i, vecs[i].x, vecs[i].e), vecs[i].y, vecs[i].v);
    end

    // Latency: a change between edges is invisible until the next rising edge.
    step(4'b0001, 1'b1);
    chk("latency_before", 2'b00, 1'b1);
    #2 x = 4'b0100;
    #1;
    chk("latency_mid_cycle", 2'b00, 1'b1);
    e = 1'b0;
    #1 e = 1'b1;
    #1;
    chk("latency_e_glitch", 2'b00, 1'b1);
    @(posedge clk);
    #1;
    chk("latency_after_edge", 2'b10, 1'b1);

    // Mid-stream reset pulse shorter than a cycle, with no clock edge during it.
    step(4'b1100, 1'b1);
    chk("stream_before_reset", 2'b11, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("midstream_reset_during", 2'b00, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("midstream_after_release", 2'b00, 1'b0);
    @(posedge clk);
    #1;
    chk("midstream_first_edge", 2'b11, 1'b1);

    // Reset spanning a clock edge must keep y cleared.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_across_edge", 2'b00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    x = 4'b0011;
    @(posedge clk);
    #1;
    chk("reset_release_new_x", 2'b01, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    n_bad++;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "timeout");
  end

endmodule
